// File: rtl/conv_encoder.sv
// Rate-1/2, constraint-length-3 convolutional encoder (g0=111, g1=101) with a
// frame-at-a-time message port, valid/ready symbol output and optional zero tail.
module conv_encoder #(
  parameter int MSG_W   = 16,
  parameter int TAIL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             msg_valid,
  input  logic [MSG_W-1:0] msg_data,
  output logic             msg_ready,
  output logic             sym_valid,
  input  logic             sym_ready,
  output logic [1:0]       sym_data,
  output logic             sym_last,
  output logic [1:0]       enc_state,
  output logic [7:0]       frame_cnt
);

  localparam int              CNT_W    = 5;
  localparam bit              HAS_TAIL = (TAIL_EN != 0);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(MSG_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, ENC, TAIL} state_t;

  state_t             state_q, state_d;
  logic [MSG_W-1:0]   shreg_q, shreg_d;
  logic [1:0]         enc_state_q, enc_state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;

  logic u;
  logic sym_fire;
  logic last_sym;

  // Everything visible on the symbol port comes from flops only.
  always_comb begin
    u        = (state_q == ENC) ? shreg_q[MSG_W-1] : 1'b0;
    sym_fire = (state_q != IDLE) && sym_ready;
    last_sym = ((state_q == TAIL) && (bit_cnt_q == CNT_ONE)) ||
               ((state_q == ENC) && !HAS_TAIL && (bit_cnt_q == LAST_BIT));
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    enc_state_d = enc_state_q;
    bit_cnt_d   = bit_cnt_q;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      IDLE: begin
        if (msg_valid) begin
          shreg_d     = msg_data;
          enc_state_d = 2'b00;
          bit_cnt_d   = '0;
          state_d     = ENC;
        end
      end
      ENC: begin
        if (sym_fire) begin
          enc_state_d = {u, enc_state_q[1]};
          shreg_d     = {shreg_q[MSG_W-2:0], 1'b0};
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = HAS_TAIL ? TAIL : IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end
      end
      TAIL: begin
        if (sym_fire) begin
          enc_state_d = {1'b0, enc_state_q[1]};
          if (bit_cnt_q == CNT_ONE) begin
            bit_cnt_d = '0;
            state_d   = IDLE;
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (sym_fire && last_sym) begin
      frame_cnt_d = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      enc_state_q <= 2'b00;
      bit_cnt_q   <= '0;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      enc_state_q <= enc_state_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // sym_data is forced to 00 outside a frame so the idle port is quiet.
  assign msg_ready = (state_q == IDLE);
  assign sym_valid = (state_q != IDLE);
  assign sym_data  = sym_valid ? {u ^ enc_state_q[1] ^ enc_state_q[0], u ^ enc_state_q[0]}
                               : 2'b00;
  assign sym_last  = last_sym;
  assign enc_state = enc_state_q;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_conv_encoder.sv
// Self-checking bench for conv_encoder: one instance with tail, one without,
// driven from a vector table plus reset-abort and queued-frame sequences.
module tb_conv_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mv;
  logic        sel;
  logic [15:0] msg_data;
  logic        sym_ready;

  logic       a_msg_valid, a_msg_ready, a_sym_valid, a_sym_last;
  logic [1:0] a_sym_data, a_enc_state;
  logic [7:0] a_frame_cnt;
  logic       b_msg_valid, b_msg_ready, b_sym_valid, b_sym_last;
  logic [1:0] b_sym_data, b_enc_state;
  logic [7:0] b_frame_cnt;

  logic       m_ready, m_valid, m_last;
  logic [1:0] m_data, m_enc;

  int checks = 0;
  int errors = 0;
  int fc_a   = 0;
  int fc_b   = 0;

  logic [2:0] sb[$];

  localparam logic [35:0] IMP    = {2'b11, 2'b10, 2'b11, 30'b0};
  localparam logic [35:0] ONES   = {2'b11, 2'b01, {14{2'b10}}, 2'b01, 2'b11};
  localparam logic [35:0] IMP_NT = {2'b11, 2'b10, 2'b11, 26'b0, 4'b0};

  typedef struct {
    logic [15:0] msg;
    logic        s;
    int          mode;
    logic        use_exp;
    logic [35:0] exp;
  } vec_t;

  always #5 clk = ~clk;

  assign a_msg_valid = mv & ~sel;
  assign b_msg_valid = mv & sel;
  assign m_ready = sel ? b_msg_ready : a_msg_ready;
  assign m_valid = sel ? b_sym_valid : a_sym_valid;
  assign m_last  = sel ? b_sym_last  : a_sym_last;
  assign m_data  = sel ? b_sym_data  : a_sym_data;
  assign m_enc   = sel ? b_enc_state : a_enc_state;

  conv_encoder #(.MSG_W(16), .TAIL_EN(1)) dut (
    .clk(clk), .rst(rst), .msg_valid(a_msg_valid), .msg_data(msg_data),
    .msg_ready(a_msg_ready), .sym_valid(a_sym_valid), .sym_ready(sym_ready),
    .sym_data(a_sym_data), .sym_last(a_sym_last), .enc_state(a_enc_state),
    .frame_cnt(a_frame_cnt)
  );

  conv_encoder #(.MSG_W(16), .TAIL_EN(0)) dut_nt (
    .clk(clk), .rst(rst), .msg_valid(b_msg_valid), .msg_data(msg_data),
    .msg_ready(b_msg_ready), .sym_valid(b_sym_valid), .sym_ready(sym_ready),
    .sym_data(b_sym_data), .sym_last(b_sym_last), .enc_state(b_enc_state),
    .frame_cnt(b_frame_cnt)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  task automatic push_exp(input logic [35:0] exp, input int nsym);
    for (int k = 0; k < nsym; k++) begin
      sb.push_back({exp[35-2*k -: 2], (k == nsym - 1)});
    end
  endtask

  // Reference trellis walk: register holds the last two input bits.
  task automatic push_model(input logic [15:0] msg, input logic tail);
    logic r1, r0, in_bit;
    int   nsym;
    r1 = 1'b0;
    r0 = 1'b0;
    nsym = tail ? 18 : 16;
    for (int k = 0; k < nsym; k++) begin
      in_bit = (k < 16) ? msg[15-k] : 1'b0;
      sb.push_back({in_bit ^ r1 ^ r0, in_bit ^ r0, (k == nsym - 1)});
      r0 = r1;
      r1 = in_bit;
    end
  endtask

  task automatic run_frame(input logic [15:0] msg, input logic s, input int mode);
    int         n;
    int         ph;
    logic       held;
    logic [1:0] hd, he;
    logic       hl;
    logic [2:0] e;
    sel = s;
    @(negedge clk);
    msg_data = msg;
    mv = 1'b1;
    n = 0;
    while (!m_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("accept_timeout", 32'(n), 32'd0);
    @(negedge clk);
    mv = 1'b0;
    chk("first_sym_valid", 32'(m_valid), 32'd1);
    held = 1'b0;
    hd = 2'b00;
    he = 2'b00;
    hl = 1'b0;
    ph = 0;
    n = 0;
    while (sb.size() > 0 && n < 400) begin
      case (mode)
        0:       sym_ready = 1'b1;
        1:       sym_ready = (ph % 2 == 0);
        default: sym_ready = 1'($urandom_range(0, 1));
      endcase
      ph++;
      if (held) chk("stall_hold", {27'b0, m_data, m_last, m_enc}, {27'b0, hd, hl, he});
      if (m_valid && sym_ready) begin
        e = sb.pop_front();
        chk("sym", {29'b0, m_data, m_last}, {29'b0, e});
      end
      held = m_valid && !sym_ready;
      hd = m_data;
      hl = m_last;
      he = m_enc;
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) chk("sym_timeout", 32'(sb.size()), 32'd0);
    sb.delete();
    sym_ready = 1'b0;
    chk("end_sym_valid", 32'(m_valid), 32'd0);
    chk("end_msg_ready", 32'(m_ready), 32'd1);
  endtask

  initial begin
    vec_t vt[6];
    int   acc, lasts, n, cnt;
    logic [2:0] e;

    vt[0] = '{16'h8000, 1'b0, 0, 1'b1, IMP};
    vt[1] = '{16'hFFFF, 1'b0, 0, 1'b1, ONES};
    vt[2] = '{16'h8000, 1'b0, 1, 1'b1, IMP};
    vt[3] = '{16'h8000, 1'b1, 0, 1'b1, IMP_NT};
    vt[4] = '{16'hA5C3, 1'b0, 2, 1'b0, 36'b0};
    vt[5] = '{16'h1234, 1'b1, 1, 1'b0, 36'b0};

    rst = 1'b1;
    mv = 1'b0;
    sel = 1'b0;
    msg_data = 16'h0;
    sym_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_msg_ready", 32'(a_msg_ready), 32'd1);
    chk("rst_sym_valid", 32'(a_sym_valid), 32'd0);
    chk("rst_sym_data",  32'(a_sym_data),  32'd0);
    chk("rst_sym_last",  32'(a_sym_last),  32'd0);
    chk("rst_enc_state", 32'(a_enc_state), 32'd0);
    chk("rst_frame_cnt", 32'(a_frame_cnt), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      if (vt[i].use_exp) push_exp(vt[i].exp, vt[i].s ? 16 : 18);
      else               push_model(vt[i].msg, !vt[i].s);
      run_frame(vt[i].msg, vt[i].s, vt[i].mode);
      if (vt[i].s) begin
        fc_b++;
        chk("frame_cnt_nt", 32'(b_frame_cnt), 32'(fc_b));
      end else begin
        fc_a++;
        chk("frame_cnt", 32'(a_frame_cnt), 32'(fc_a));
        chk("enc_state_end", 32'(a_enc_state), 32'd0);
      end
    end

    // Abort a frame with reset after its 5th symbol, then encode cleanly.
    sel = 1'b0;
    push_model(16'hFFFF, 1'b1);
    @(negedge clk);
    msg_data = 16'hFFFF;
    mv = 1'b1;
    @(negedge clk);
    mv = 1'b0;
    sym_ready = 1'b1;
    cnt = 0;
    n = 0;
    while (cnt < 5 && n < 50) begin
      if (a_sym_valid) begin
        e = sb.pop_front();
        chk("abort_sym", {29'b0, a_sym_data, a_sym_last}, {29'b0, e});
        cnt++;
      end
      @(negedge clk);
      n++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sym_ready = 1'b0;
    sb.delete();
    fc_a = 0;
    fc_b = 0;
    chk("abort_sym_valid", 32'(a_sym_valid), 32'd0);
    chk("abort_frame_cnt", 32'(a_frame_cnt), 32'd0);
    chk("abort_msg_ready", 32'(a_msg_ready), 32'd1);
    push_exp(IMP, 18);
    run_frame(16'h8000, 1'b0, 0);
    fc_a++;
    chk("post_abort_frame_cnt", 32'(a_frame_cnt), 32'(fc_a));

    // Two frames with msg_valid held; payload changes after the first accept.
    sel = 1'b0;
    push_exp(IMP, 18);
    push_exp(ONES, 18);
    @(negedge clk);
    msg_data = 16'h8000;
    mv = 1'b1;
    sym_ready = 1'b1;
    acc = 0;
    lasts = 0;
    n = 0;
    while ((acc < 2 || sb.size() > 0) && n < 200) begin
      if (mv && a_msg_ready) begin
        chk("accept_order", 32'(lasts), 32'(acc));
        acc++;
      end
      if (a_sym_valid && sym_ready) begin
        e = sb.pop_front();
        chk("queued_sym", {29'b0, a_sym_data, a_sym_last}, {29'b0, e});
        if (a_sym_last) lasts++;
      end
      @(negedge clk);
      n++;
      if (acc == 1) msg_data = 16'hFFFF;
      if (acc == 2) mv = 1'b0;
    end
    if (sb.size() > 0 || acc < 2) chk("queued_timeout", 32'(acc), 32'd2);
    sb.delete();
    sym_ready = 1'b0;
    fc_a += 2;
    chk("queued_frame_cnt", 32'(a_frame_cnt), 32'(fc_a));
    chk("queued_enc_state", 32'(a_enc_state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
